// File: rtl/entropy_source_conditioner_pkg.sv
// Shared constants for the entropy source conditioner: cond_state encoding and parameter defaults.
package entropy_source_conditioner_pkg;

   localparam logic [1:0] COND_STARTUP = 2'd0;
   localparam logic [1:0] COND_RUN     = 2'd1;
   localparam logic [1:0] COND_FAIL    = 2'd2;

   localparam int WORD_W_DEF        = 16;
   localparam int REP_LIMIT_DEF     = 32;
   localparam int APT_WINDOW_DEF    = 64;
   localparam int APT_CUTOFF_DEF    = 52;
   localparam int STARTUP_WORDS_DEF = 4;

endpackage

// File: rtl/entropy_source_conditioner_health.sv
// Repetition-count and adaptive-proportion tests on the raw TRNG stream.
// fail_o is combinational on the cycle the offending bit is accepted.
module entropy_health_test
   import entropy_source_conditioner_pkg::*;
#(
   parameter int REP_LIMIT  = REP_LIMIT_DEF,
   parameter int APT_WINDOW = APT_WINDOW_DEF,
   parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_i,
   input  logic valid_i,
   input  logic clear_i,
   output logic fail_o
);

   localparam int REP_W = $clog2(REP_LIMIT + 1);
   localparam int WIN_W = $clog2(APT_WINDOW);
   localparam int ONE_W = $clog2(APT_WINDOW + 1);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);
   localparam logic [ONE_W-1:0] ONES_HI  = ONE_W'(APT_CUTOFF);
   localparam logic [ONE_W-1:0] ONES_LO  = ONE_W'(APT_WINDOW - APT_CUTOFF);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             prev_bit_q, prev_bit_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [ONE_W-1:0] ones_q, ones_d, ones_inc;
   logic             rep_fail, apt_fail;

   always_comb begin
      rep_cnt_d  = rep_cnt_q;
      prev_bit_d = prev_bit_q;
      win_cnt_d  = win_cnt_q;
      ones_d     = ones_q;
      ones_inc   = ones_q + ONE_W'(bit_i);
      rep_fail   = 1'b0;
      apt_fail   = 1'b0;
      if (clear_i) begin
         rep_cnt_d  = '0;
         prev_bit_d = 1'b0;
         win_cnt_d  = '0;
         ones_d     = '0;
      end else if (valid_i) begin
         prev_bit_d = bit_i;
         // A zero run count marks "no previous bit" after reset or clear.
         if (rep_cnt_q == '0 || bit_i != prev_bit_q)
            rep_cnt_d = REP_W'(1);
         else if (rep_cnt_q != REP_MAX)
            rep_cnt_d = rep_cnt_q + 1'b1;
         rep_fail = (rep_cnt_d == REP_MAX);
         if (win_cnt_q == WIN_LAST) begin
            apt_fail  = (ones_inc > ONES_HI) || (ones_inc < ONES_LO);
            win_cnt_d = '0;
            ones_d    = '0;
         end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            ones_d    = ones_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_q  <= '0;
         prev_bit_q <= 1'b0;
         win_cnt_q  <= '0;
         ones_q     <= '0;
      end else begin
         rep_cnt_q  <= rep_cnt_d;
         prev_bit_q <= prev_bit_d;
         win_cnt_q  <= win_cnt_d;
         ones_q     <= ones_d;
      end
   end

   assign fail_o = rep_fail | apt_fail;

endmodule

// File: rtl/entropy_source_conditioner.sv
// Health-tested raw bit packer with valid/ready output; optional debias via VON_NEUMANN_DEBIAS_EN.
// state   | meaning
// STARTUP | discard first STARTUP_WORDS words ; RUN | present words ; FAIL | output blocked until clear_fail
module entropy_source_conditioner
   import entropy_source_conditioner_pkg::*;
#(
   parameter int WORD_W        = WORD_W_DEF,
   parameter int REP_LIMIT     = REP_LIMIT_DEF,
   parameter int APT_WINDOW    = APT_WINDOW_DEF,
   parameter int APT_CUTOFF    = APT_CUTOFF_DEF,
   parameter int STARTUP_WORDS = STARTUP_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              raw_bit_in,
   input  logic              raw_bit_valid,
   input  logic              entropy_word_ready,
   input  logic              clear_fail,
   output logic [WORD_W-1:0] entropy_word_out,
   output logic              entropy_word_valid,
   output logic              health_fail,
   output logic [1:0]        cond_state,
   output logic [7:0]        drop_count
);

   localparam int BIT_W = $clog2(WORD_W);
   localparam int SW_W  = $clog2(STARTUP_WORDS + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [SW_W-1:0]  SW_LAST  = SW_W'(STARTUP_WORDS - 1);

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d, word_full;
   logic [WORD_W-1:0] out_q, out_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SW_W-1:0]   start_cnt_q, start_cnt_d;
   logic              valid_q, valid_d;
   logic [7:0]        drop_q, drop_d;
   logic              bit_acc, hfail, pack_en, pack_bit, word_done;

   assign bit_acc = raw_bit_valid && (state_q != COND_FAIL);

   entropy_health_test #(
      .REP_LIMIT (REP_LIMIT),
      .APT_WINDOW(APT_WINDOW),
      .APT_CUTOFF(APT_CUTOFF)
   ) u_health (
      .clk    (clk),
      .reset  (reset),
      .bit_i  (raw_bit_in),
      .valid_i(bit_acc),
      .clear_i(state_q == COND_FAIL),
      .fail_o (hfail)
   );

`ifdef VON_NEUMANN_DEBIAS_EN
   logic vn_pend_q, vn_pend_d, vn_first_q, vn_first_d;

   always_comb begin
      vn_pend_d  = vn_pend_q;
      vn_first_d = vn_first_q;
      pack_en    = 1'b0;
      pack_bit   = vn_first_q;
      if (state_q == COND_FAIL || hfail) begin
         vn_pend_d = 1'b0;
      end else if (bit_acc) begin
         if (!vn_pend_q) begin
            vn_pend_d  = 1'b1;
            vn_first_d = raw_bit_in;
         end else begin
            // 01 emits 0 and 10 emits 1, i.e. the first bit of an unequal pair.
            vn_pend_d = 1'b0;
            pack_en   = (vn_first_q != raw_bit_in);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vn_pend_q  <= 1'b0;
         vn_first_q <= 1'b0;
      end else begin
         vn_pend_q  <= vn_pend_d;
         vn_first_q <= vn_first_d;
      end
   end
`else
   assign pack_en  = bit_acc;
   assign pack_bit = raw_bit_in;
`endif

   assign word_full = {shift_q[WORD_W-2:0], pack_bit};
   assign word_done = pack_en && (bit_cnt_q == BIT_LAST);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      start_cnt_d = start_cnt_q;
      out_d       = out_q;
      valid_d     = valid_q;
      drop_d      = drop_q;
      if (valid_q && entropy_word_ready)
         valid_d = 1'b0;
      if (pack_en) begin
         shift_d   = word_full;
         bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
      end
      case (state_q)
         COND_STARTUP: begin
            if (word_done) begin
               if (start_cnt_q == SW_LAST) begin
                  state_d     = COND_RUN;
                  start_cnt_d = '0;
               end else begin
                  start_cnt_d = start_cnt_q + 1'b1;
               end
            end
         end
         COND_RUN: begin
            if (word_done) begin
               if (!valid_q || entropy_word_ready) begin
                  out_d   = word_full;
                  valid_d = 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end
         default: begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            start_cnt_d = '0;
            out_d       = '0;
            valid_d     = 1'b0;
            if (clear_fail)
               state_d = COND_STARTUP;
         end
      endcase
      // A failure wins over a word completing on the same bit; that word is not a backpressure drop.
      if (hfail && state_q != COND_FAIL) begin
         state_d     = COND_FAIL;
         shift_d     = '0;
         bit_cnt_d   = '0;
         start_cnt_d = '0;
         out_d       = '0;
         valid_d     = 1'b0;
         drop_d      = drop_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= COND_STARTUP;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         start_cnt_q <= '0;
         out_q       <= '0;
         valid_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         start_cnt_q <= start_cnt_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         drop_q      <= drop_d;
      end
   end

   assign entropy_word_out   = out_q;
   assign entropy_word_valid = valid_q;
   assign health_fail        = (state_q == COND_FAIL);
   assign cond_state         = state_q;
   assign drop_count         = drop_q;

endmodule

// File: tb/tb_entropy_source_conditioner.sv
// Directed bench for entropy_source_conditioner; exercises the debias path when VON_NEUMANN_DEBIAS_EN is defined.
module tb_entropy_source_conditioner;

   logic        clk;
   logic        reset;
   logic        raw_bit_in;
   logic        raw_bit_valid;
   logic        entropy_word_ready;
   logic        clear_fail;
   logic [15:0] entropy_word_out;
   logic        entropy_word_valid;
   logic        health_fail;
   logic [1:0]  cond_state;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;

   entropy_source_conditioner dut (
      .clk               (clk),
      .reset             (reset),
      .raw_bit_in        (raw_bit_in),
      .raw_bit_valid     (raw_bit_valid),
      .entropy_word_ready(entropy_word_ready),
      .clear_fail        (clear_fail),
      .entropy_word_out  (entropy_word_out),
      .entropy_word_valid(entropy_word_valid),
      .health_fail       (health_fail),
      .cond_state        (cond_state),
      .drop_count        (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the following falling edge.
   task automatic send_bit(input logic b);
      raw_bit_in    = b;
      raw_bit_valid = 1'b1;
      @(negedge clk);
      raw_bit_valid = 1'b0;
   endtask

   task automatic send_alt(input int n);
      for (int i = 0; i < n; i++) send_bit(i % 2 == 0);
   endtask

   task automatic send_ones(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; raw_bit_in = 1'b0; raw_bit_valid = 1'b0;
      entropy_word_ready = 1'b0; clear_fail = 1'b0;
      idle(2);
      check("rst_out", entropy_word_out, 16'h0000);
      check("rst_valid", entropy_word_valid, 1'b0);
      check("rst_hfail", health_fail, 1'b0);
      check("rst_state", cond_state, 2'd0);
      check("rst_drop", drop_count, 8'd0);
      reset = 1'b0;

`ifdef VON_NEUMANN_DEBIAS_EN
      entropy_word_ready = 1'b1;
      for (int k = 0; k < 32; k++) begin
         send_bit(0); send_bit(1); send_bit(1); send_bit(0);
         send_bit(0); send_bit(0); send_bit(1); send_bit(1);
      end
      check("vn_run", cond_state, 2'd1);
      check("vn_valid0", entropy_word_valid, 1'b0);
      for (int k = 0; k < 8; k++) begin
         send_bit(0); send_bit(1); send_bit(1); send_bit(0);
         send_bit(0); send_bit(0); send_bit(1); send_bit(1);
      end
      check("vn_valid", entropy_word_valid, 1'b1);
      check("vn_word", entropy_word_out, 16'h5555);
      check("vn_hfail", health_fail, 1'b0);
`else
      // Startup discard then first word
      entropy_word_ready = 1'b1;
      send_alt(48);
      check("startup_hold", cond_state, 2'd0);
      send_alt(16);
      check("to_run", cond_state, 2'd1);
      check("startup_no_valid", entropy_word_valid, 1'b0);
      send_alt(15);
      check("w5_not_yet", entropy_word_valid, 1'b0);
      send_bit(1'b0);
      check("w5_valid", entropy_word_valid, 1'b1);
      check("w5_word", entropy_word_out, 16'hAAAA);

      // Repetition failure
      send_ones(31);
      check("rep31_run", cond_state, 2'd1);
      send_bit(1'b1);
      check("rep_hfail", health_fail, 1'b1);
      check("rep_state", cond_state, 2'd2);
      check("rep_valid", entropy_word_valid, 1'b0);
      check("rep_out", entropy_word_out, 16'h0000);
      send_alt(40);
      check("fail_block_valid", entropy_word_valid, 1'b0);
      check("fail_stay", cond_state, 2'd2);

      // Clear and re-run startup
      clear_fail = 1'b1;
      idle(1);
      clear_fail = 1'b0;
      check("clr_state", cond_state, 2'd0);
      check("clr_hfail", health_fail, 1'b0);
      send_alt(63);
      check("clr_startup_hold", cond_state, 2'd0);
      send_bit(1'b0);
      check("clr_to_run", cond_state, 2'd1);

      // Backpressure
      entropy_word_ready = 1'b0;
      send_word(16'h1234);
      check("bp_w1_valid", entropy_word_valid, 1'b1);
      check("bp_w1", entropy_word_out, 16'h1234);
      send_word(16'h5678);
      send_word(16'h9ABC);
      check("bp_held", entropy_word_out, 16'h1234);
      check("bp_valid", entropy_word_valid, 1'b1);
      check("bp_drop", drop_count, 8'd2);
      entropy_word_ready = 1'b1;
      idle(1);
      check("bp_xfer_valid", entropy_word_valid, 1'b0);
      entropy_word_ready = 1'b0;

      // APT window with 53 ones
      do_reset();
      entropy_word_ready = 1'b1;
      send_alt(64);
      check("apt53_run", cond_state, 2'd1);
      for (int i = 0; i < 63; i++) send_bit(i % 6 != 0);
      check("apt53_before", cond_state, 2'd1);
      send_bit(1'b1);
      check("apt53_state", cond_state, 2'd2);
      check("apt53_hfail", health_fail, 1'b1);
      check("apt53_drop_kept", drop_count, 8'd0);

      // APT window with exactly 52 ones
      do_reset();
      send_alt(64);
      for (int i = 0; i < 63; i++) send_bit(i % 6 != 0);
      send_bit(1'b0);
      check("apt52_state", cond_state, 2'd1);
      check("apt52_hfail", health_fail, 1'b0);
      check("apt52_valid", entropy_word_valid, 1'b1);
      check("apt52_word", entropy_word_out, 16'h7DF6);

      // clear_fail coincident with a new failure in RUN
      send_ones(31);
      check("same_pre", cond_state, 2'd1);
      clear_fail = 1'b1;
      send_bit(1'b1);
      clear_fail = 1'b0;
      check("same_cycle_fail", cond_state, 2'd2);
      idle(2);
      check("same_cycle_stay", cond_state, 2'd2);
      check("same_cycle_out", entropy_word_out, 16'h0000);

      // Reset mid-word
      do_reset();
      send_alt(64);
      send_alt(16);
      check("mid_valid_pre", entropy_word_valid, 1'b1);
      check("mid_word_pre", entropy_word_out, 16'hAAAA);
      send_alt(8);
      do_reset();
      check("mid_rst_valid", entropy_word_valid, 1'b0);
      check("mid_rst_out", entropy_word_out, 16'h0000);
      check("mid_rst_state", cond_state, 2'd0);
      send_alt(56);
      check("mid_partial_lost", cond_state, 2'd0);
      send_alt(8);
      check("mid_run", cond_state, 2'd1);
      entropy_word_ready = 1'b1;
      send_word(16'h3C3C);
      check("mid_new_word", entropy_word_out, 16'h3C3C);
      check("mid_new_valid", entropy_word_valid, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
